// File: rtl/regfile_mp.sv
// Multi-ported register file with same-cycle write bypass, pending-bit scoreboard
// and a handshaked dump engine that streams every register out in index order.
module regfile_mp #(
   parameter int DATA_WIDTH    = 64,
   parameter int REG_COUNT_LOG = 5,
   parameter int NUM_READ      = 2,
   parameter int NUM_WRITE     = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_READ*REG_COUNT_LOG-1:0] rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
   output logic [NUM_READ-1:0]               rd_busy,
   input  logic [NUM_WRITE-1:0]              wr_en,
   input  logic [NUM_WRITE*REG_COUNT_LOG-1:0] wr_addr,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0]   wr_data,
   input  logic                              claim_en,
   input  logic [REG_COUNT_LOG-1:0]          claim_addr,
   input  logic                              dump_start,
   output logic                              dump_valid,
   input  logic                              dump_ready,
   output logic [REG_COUNT_LOG-1:0]          dump_idx,
   output logic [DATA_WIDTH-1:0]             dump_data,
   output logic                              dump_busy
);

   localparam int REGS = 1 << REG_COUNT_LOG;

   typedef enum logic {IDLE, STREAM} dump_state_t;

   logic [DATA_WIDTH-1:0]    regs [REGS];
   logic [REGS-1:0]          pending;
   logic [REGS-1:0]          pending_next;
   dump_state_t              state;
   dump_state_t              state_next;
   logic [REG_COUNT_LOG-1:0] idx_next;

   // Ports are visited in ascending order, so the highest-index writer lands last.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_WRITE; k++) begin
            if (wr_en[k] && (wr_addr[k*REG_COUNT_LOG +: REG_COUNT_LOG] != '0)) begin
               regs[wr_addr[k*REG_COUNT_LOG +: REG_COUNT_LOG]] <= wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // The claim is applied after the writeback clears so a newer producer keeps the bit.
   always_comb begin
      pending_next = pending;
      for (int k = 0; k < NUM_WRITE; k++) begin
         if (wr_en[k] && (wr_addr[k*REG_COUNT_LOG +: REG_COUNT_LOG] != '0)) begin
            pending_next[wr_addr[k*REG_COUNT_LOG +: REG_COUNT_LOG]] = 1'b0;
         end
      end
      if (claim_en && (claim_addr != '0)) begin
         pending_next[claim_addr] = 1'b1;
      end
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
      logic [REG_COUNT_LOG-1:0] addr;
      logic [DATA_WIDTH-1:0]    data;
      logic                     hit;

      assign addr = rd_addr[r*REG_COUNT_LOG +: REG_COUNT_LOG];

      always_comb begin
         data = regs[addr];
         hit  = 1'b0;
         for (int k = 0; k < NUM_WRITE; k++) begin
            if (wr_en[k] && (wr_addr[k*REG_COUNT_LOG +: REG_COUNT_LOG] == addr)) begin
               data = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
               hit  = 1'b1;
            end
         end
         if (addr == '0) begin
            data = '0;
            hit  = 1'b0;
         end
      end

      assign rd_data[r*DATA_WIDTH +: DATA_WIDTH] = data;
      assign rd_busy[r] = pending[addr] & ~hit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         dump_idx <= '0;
      end else begin
         state    <= state_next;
         dump_idx <= idx_next;
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = dump_idx;
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
      case (state)
         IDLE: begin
            if (dump_start) begin
               state_next = STREAM;
               idx_next   = '0;
            end
         end
         STREAM: begin
            dump_valid = 1'b1;
            dump_busy  = 1'b1;
            if (dump_ready) begin
               if (dump_idx == '1) begin
                  state_next = IDLE;
                  idx_next   = '0;
               end else begin
                  idx_next = dump_idx + REG_COUNT_LOG'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
            idx_next   = '0;
         end
      endcase
   end

   // Dump beats read storage directly; same-cycle writes are not bypassed here.
   assign dump_data = regs[dump_idx];

endmodule
